// File: rtl/vs_pkg.sv
// Shared types and helpers for the valid/stall FIFO family.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package vs_pkg;

    localparam int VS_DEF_WIDTH = 32;
    localparam int VS_DEF_DEPTH = 6;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int vs_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // One valid/stall handshake beat at the default payload width.
    typedef struct packed {
        logic                    valid;
        logic [VS_DEF_WIDTH-1:0] data;
    } vs_hs_t;

endpackage

// File: rtl/ptr_wrap.sv
// Wrap-around pointer 0..N-1 with increment and synchronous clear; works for any N >= 2.
// Latency: new value visible one cycle after inc/clr.
// Backpressure: none; the caller decides when to increment.
module ptr_wrap #(
    parameter int N = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 inc,
    output logic [$clog2(N)-1:0] ptr
);
    localparam int PW = $clog2(N);

    // Pointer register: reset/clear dominate, then wrap N-1 -> 0 on increment.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == PW'(N - 1)) ? '0 : ptr + PW'(1);
        end
    end

endmodule

// File: rtl/vs_fifo_n.sv
// Valid/stall FIFO of arbitrary depth with occupancy count, almost-full flag and flush; VS_FIFO_BYPASS_EN adds empty-bypass.
// Latency: one cycle push-to-output by default; zero cycles through the bypass when VS_FIFO_BYPASS_EN is defined.
// Backpressure: stall_us = registered full & valid_us, so a pop never frees a slot in the same cycle.
module vs_fifo_n
    import vs_pkg::*;
#(
    parameter int WIDTH     = VS_DEF_WIDTH,
    parameter int DEPTH     = VS_DEF_DEPTH,
    parameter int AF_THRESH = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       valid_us,
    input  logic [WIDTH-1:0]           data_us,
    output logic                       stall_us,
    output logic                       valid_ds,
    output logic [WIDTH-1:0]           data_ds,
    input  logic                       stall_ds,
    output logic [vs_cnt_w(DEPTH)-1:0] count,
    output logic                       almost_full,
    output logic                       empty,
    output logic                       full
);
    localparam int CNT_W = vs_cnt_w(DEPTH);
    localparam int PW    = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CNT_W-1:0] count_r;
    logic             push;
    logic             pop;
    logic             byp;
    logic             wr_inc;
    logic             rd_inc;

    assign count       = count_r;
    assign empty       = (count_r == '0);
    assign full        = (count_r == CNT_W'(DEPTH));
    assign almost_full = (count_r >= CNT_W'(AF_THRESH));

    // Upstream stall only looks at registered full, never at stall_ds.
    assign stall_us = full & valid_us;
    assign push     = valid_us & ~stall_us;

`ifdef VS_FIFO_BYPASS_EN
    // An empty FIFO hands the upstream word straight through when downstream can take it.
    assign byp      = empty & valid_us & ~stall_ds;
    assign valid_ds = ~empty | byp;
    assign data_ds  = ~empty ? mem[rd_ptr] : (byp ? data_us : '0);
`else
    // Downstream sees registered state only.
    assign byp      = 1'b0;
    assign valid_ds = ~empty;
    assign data_ds  = ~empty ? mem[rd_ptr] : '0;
`endif

    assign pop = valid_ds & ~stall_ds;

    // A bypassed word is consumed without touching storage or pointers.
    assign wr_inc = push & ~byp & ~clr;
    assign rd_inc = pop & ~empty & ~clr;

    ptr_wrap #(.N(DEPTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (wr_inc),
        .ptr (wr_ptr)
    );

    ptr_wrap #(.N(DEPTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (rd_inc),
        .ptr (rd_ptr)
    );

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_inc) begin
            mem[wr_ptr] <= data_us;
        end
    end

    // Occupancy: +1 push only, -1 pop only, hold on both or neither.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (wr_inc && !rd_inc) begin
            count_r <= count_r + CNT_W'(1);
        end else if (rd_inc && !wr_inc) begin
            count_r <= count_r - CNT_W'(1);
        end
    end

`ifndef SYNTHESIS
    // Upstream must hold its word while stalled.
    a_us_hold: assert property (@(posedge clk) disable iff (!rst)
        stall_us |=> (valid_us && $stable(data_us)));

    // Storage is never read out while empty, whatever stall_ds does.
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst)
        !(rd_inc && empty));
`endif

endmodule

// File: tb/tb_vs_fifo_n.sv
// Directed bench for vs_fifo_n at WIDTH=8, DEPTH=5, AF_THRESH=4.
// Latency: inputs driven 1ns after the rising edge, outputs checked 1ns later.
// Backpressure: exercised through stall_ds patterns and the full boundary.
module tb_vs_fifo_n;

    localparam int W   = 8;
    localparam int D   = 5;
    localparam int AF  = 4;
    localparam int CW  = 3;
`ifdef VS_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic          valid_us;
    logic [W-1:0]  data_us;
    logic          stall_us;
    logic          valid_ds;
    logic [W-1:0]  data_ds;
    logic          stall_ds;
    logic [CW-1:0] count;
    logic          almost_full;
    logic          empty;
    logic          full;

    int checks   = 0;
    int failures = 0;

    vs_fifo_n #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF)) dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .valid_us    (valid_us),
        .data_us     (data_us),
        .stall_us    (stall_us),
        .valid_ds    (valid_ds),
        .data_ds     (data_ds),
        .stall_ds    (stall_ds),
        .count       (count),
        .almost_full (almost_full),
        .empty       (empty),
        .full        (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1ns past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Settle combinational outputs for the current inputs.
    task automatic settle();
        #1;
    endtask

    // Fill n words base, base+1, ... with downstream stalled.
    task automatic fill(input logic [W-1:0] base, input int n);
        stall_ds = 1'b1;
        for (int i = 0; i < n; i++) begin
            valid_us = 1'b1;
            data_us  = base + W'(i);
            tick();
        end
        valid_us = 1'b0;
        data_us  = '0;
    endtask

    initial begin
        rst = 1'b0; clr = 1'b0; valid_us = 1'b0; data_us = '0; stall_ds = 1'b0;

        // 1. Reset state
        tick(); tick();
        settle();
        check("rst_valid_ds", 32'(valid_ds), 32'd0);
        check("rst_data_ds",  32'(data_ds),  32'd0);
        check("rst_count",    32'(count),    32'd0);
        check("rst_empty",    32'(empty),    32'd1);
        check("rst_full",     32'(full),     32'd0);
        check("rst_af",       32'(almost_full), 32'd0);
        check("rst_stall_us", 32'(stall_us), 32'd0);
        rst = 1'b1;
        tick();

        // 2. Fill to full with downstream stalled, hold a sixth word, then drain
        stall_ds = 1'b1;
        for (int i = 0; i < 5; i++) begin
            valid_us = 1'b1;
            data_us  = 8'h11 + 8'(i);
            settle();
            check("fill_stall_us", 32'(stall_us), 32'd0);
            if (i == 0 && !BYP) check("fill_no_early_valid", 32'(valid_ds), 32'd0);
            tick();
            check("fill_count", 32'(count), 32'(i + 1));
            check("fill_af",    32'(almost_full), (i + 1 >= 4) ? 32'd1 : 32'd0);
            check("fill_head",  32'(data_ds), 32'h11);
        end
        check("fill_full", 32'(full), 32'd1);
        data_us = 8'h16;
        settle();
        check("held_stall_us", 32'(stall_us), 32'd1);
        tick();
        check("held_count", 32'(count), 32'd5);
        stall_ds = 1'b0;
        settle();
        check("fullpop_stall_us", 32'(stall_us), 32'd1);
        check("fullpop_data", 32'(data_ds), 32'h11);
        tick();
        check("afterpop_count", 32'(count), 32'd4);
        check("afterpop_stall_us", 32'(stall_us), 32'd0);
        check("afterpop_data", 32'(data_ds), 32'h12);
        tick();
        valid_us = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("drain2_data",  32'(data_ds), 32'h13 + 32'(i));
            check("drain2_count", 32'(count), 32'(4 - i));
            tick();
        end
        check("drain2_empty", 32'(empty), 32'd1);
        check("drain2_valid", 32'(valid_ds), 32'd0);

        // 3. Streaming push/pop; pointers wrap twice
        stall_ds = 1'b0;
        for (int i = 0; i < 12; i++) begin
            valid_us = 1'b1;
            data_us  = W'(i);
            settle();
            if (BYP) begin
                check("stream_byp_data", 32'(data_ds), 32'(i));
                check("stream_byp_count", 32'(count), 32'd0);
            end else if (i == 0) begin
                check("stream_first_valid", 32'(valid_ds), 32'd0);
            end else begin
                check("stream_valid", 32'(valid_ds), 32'd1);
                check("stream_data",  32'(data_ds), 32'(i - 1));
                check("stream_count", 32'(count), 32'd1);
            end
            tick();
        end
        valid_us = 1'b0;
        settle();
        if (!BYP) check("stream_last", 32'(data_ds), 32'h0B);
        tick();
        check("stream_empty", 32'(empty), 32'd1);

        // 4. Full with pop and push pending
        fill(8'h20, 5);
        check("f4_full", 32'(full), 32'd1);
        valid_us = 1'b1; data_us = 8'h25; stall_ds = 1'b0;
        settle();
        check("f4_stall_us", 32'(stall_us), 32'd1);
        check("f4_data0", 32'(data_ds), 32'h20);
        tick();
        check("f4_count1", 32'(count), 32'd4);
        check("f4_stall_us1", 32'(stall_us), 32'd0);
        check("f4_data1", 32'(data_ds), 32'h21);
        tick();
        check("f4_count2", 32'(count), 32'd4);
        valid_us = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("f4_drain", 32'(data_ds), 32'h22 + 32'(i));
            tick();
        end
        check("f4_empty", 32'(empty), 32'd1);

        // 5. Flush with simultaneous push and pop
        fill(8'h30, 3);
        check("f5_count", 32'(count), 32'd3);
        clr = 1'b1; valid_us = 1'b1; data_us = 8'h77; stall_ds = 1'b0;
        settle();
        check("f5_head", 32'(data_ds), 32'h30);
        tick();
        clr = 1'b0; valid_us = 1'b0; data_us = '0;
        settle();
        check("f5_count0", 32'(count), 32'd0);
        check("f5_empty",  32'(empty), 32'd1);
        check("f5_valid",  32'(valid_ds), 32'd0);
        check("f5_data",   32'(data_ds), 32'd0);
        tick();
        check("f5_still_empty", 32'(valid_ds), 32'd0);

        // Reset mid-stream drops all contents
        fill(8'h40, 2);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        settle();
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_valid", 32'(valid_ds), 32'd0);
        tick();

`ifdef VS_FIFO_BYPASS_EN
        // 6. Bypass on empty
        valid_us = 1'b1; data_us = 8'hA5; stall_ds = 1'b0;
        settle();
        check("byp_valid", 32'(valid_ds), 32'd1);
        check("byp_data",  32'(data_ds), 32'hA5);
        tick();
        check("byp_count", 32'(count), 32'd0);
        stall_ds = 1'b1;
        settle();
        check("byp_stalled_valid", 32'(valid_ds), 32'd0);
        tick();
        valid_us = 1'b0;
        settle();
        check("byp_stalled_count", 32'(count), 32'd1);
        check("byp_stalled_data", 32'(data_ds), 32'hA5);
        stall_ds = 1'b0;
        tick();
        check("byp_drained", 32'(empty), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
